// File: rtl/random_range_sampler.sv
// Rejection sampler: packs serial LFSR bits into WIDTH-bit candidates, keeps those
// below RANGE, and hands them out through a 2-entry valid/ready FIFO.
module random_range_sampler #(
  parameter int WIDTH = 3,
  parameter int RANGE = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] reject_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       level
);

  localparam int               BCW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0]   LAST    = BCW'(WIDTH - 1);
  localparam logic [WIDTH:0]   RANGE_V = (WIDTH + 1)'(RANGE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [BCW-1:0]   bit_cnt;
  logic [1:0]       lvl;
  logic             complete;
  logic             in_range;
  logic             pop;
  logic             push;
  logic             rej;
  logic             drop;

  // First received bit ends up as the MSB of the candidate.
  generate
    if (WIDTH == 1) begin : g_w1
      assign cand = in_bit;
    end else begin : g_wn
      assign cand = {sr[WIDTH-2:0], in_bit};
    end
  endgenerate

  assign complete = in_valid && (bit_cnt == LAST) && !clear;
  assign in_range = {1'b0, cand} < RANGE_V;
  assign pop      = out_valid && out_ready && !clear;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = complete && in_range && ((lvl != 2'd2) || pop);
  assign rej      = complete && !in_range;
  assign drop     = complete && in_range && !push;

  assign out_value = head;
  assign out_valid = (lvl != 2'd0);
  assign level     = lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (in_valid) begin
      sr      <= cand;
      bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reject_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (rej && (reject_cnt != CNT_MAX)) reject_cnt <= reject_cnt + 1'b1;
      if (drop && (drop_cnt != CNT_MAX))  drop_cnt   <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      lvl  <= 2'd0;
    end else if (clear) begin
      lvl <= 2'd0;
    end else begin
      case (lvl)
        2'd0: begin
          if (push) begin
            head <= cand;
            lvl  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= cand;
          end else if (push) begin
            tail <= cand;
            lvl  <= 2'd2;
          end else if (pop) begin
            lvl <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head <= tail;
            if (push) tail <= cand;
            else      lvl  <= 2'd1;
          end
        end
        default: lvl <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_random_range_sampler.sv
// Directed bench for random_range_sampler (WIDTH=3, RANGE=6, CNT_W=2) with
// hand-computed expected values.
module tb_random_range_sampler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] out_value;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] reject_cnt;
  logic [1:0] drop_cnt;
  logic [1:0] level;

  int checks = 0;
  int errors = 0;

  random_range_sampler #(.WIDTH(3), .RANGE(6), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .out_value  (out_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .reject_cnt (reject_cnt),
    .drop_cnt   (drop_cnt),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_val(input logic [2:0] v);
    logic [2:0] t;
    t = v;
    send_bit(t[2]);
    send_bit(t[1]);
    send_bit(t[0]);
  endtask

  initial begin
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_value", out_value, 0);
    chk("rst_level", level, 0);
    chk("rst_reject", reject_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    tick();

    // basic push, 1-cycle latency, single-cycle valid
    out_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    chk("basic_early", out_valid, 0);
    send_bit(1'b0);
    chk("basic_valid", out_valid, 1);
    chk("basic_value", out_value, 2);
    chk("basic_level", level, 1);
    tick();
    chk("basic_gone", out_valid, 0);
    chk("basic_level0", level, 0);

    // rejection
    send_val(3'd7);
    chk("rej7_valid", out_valid, 0);
    send_val(3'd6);
    chk("rej6_valid", out_valid, 0);
    chk("rej_cnt", reject_cnt, 2);
    send_val(3'd5);
    chk("acc5_valid", out_valid, 1);
    chk("acc5_value", out_value, 5);
    tick();
    chk("acc5_gone", level, 0);

    // backpressure and drop
    out_ready = 1'b0;
    send_val(3'd1);
    chk("bp1_level", level, 1);
    chk("bp1_value", out_value, 1);
    send_val(3'd2);
    chk("bp2_level", level, 2);
    chk("bp2_value", out_value, 1);
    send_val(3'd3);
    chk("bp3_level", level, 2);
    chk("bp3_value", out_value, 1);
    chk("bp_drop", drop_cnt, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_value", out_value, 2);
    chk("bp_pop1_level", level, 1);
    tick();
    chk("bp_pop2_level", level, 0);

    // full with simultaneous push and pop
    out_ready = 1'b0;
    send_val(3'd1);
    send_val(3'd2);
    chk("full_level", level, 2);
    send_bit(1'b1);
    send_bit(1'b0);
    out_ready = 1'b1;
    send_bit(1'b0);
    chk("pp_level", level, 2);
    chk("pp_value", out_value, 2);
    chk("pp_drop", drop_cnt, 1);
    tick();
    chk("pp_next_value", out_value, 4);
    chk("pp_next_level", level, 1);
    tick();
    chk("pp_empty", level, 0);

    // gaps in in_valid
    send_bit(1'b0);
    in_bit = 1'b1;
    tick();
    tick();
    send_bit(1'b1);
    tick();
    chk("gap_early", out_valid, 0);
    send_bit(1'b1);
    chk("gap_valid", out_valid, 1);
    chk("gap_value", out_value, 3);
    tick();

    // reset after 2 of 3 bits discards the partial candidate
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    #2;
    chk("arst_level", level, 0);
    chk("arst_reject", reject_cnt, 0);
    chk("arst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    tick();
    send_val(3'd4);
    chk("arst_valid", out_valid, 1);
    chk("arst_value", out_value, 4);
    chk("arst_reject2", reject_cnt, 0);
    tick();

    // counter saturation
    for (int i = 0; i < 5; i++) send_val(3'd7);
    chk("sat_reject", reject_cnt, 3);
    chk("sat_valid", out_valid, 0);

    // clear with level=1 and a partial collection pending
    out_ready = 1'b0;
    send_val(3'd1);
    chk("clr_pre_level", level, 1);
    send_bit(1'b1);
    send_bit(1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_level", level, 0);
    chk("clr_reject", reject_cnt, 3);
    out_ready = 1'b1;
    send_val(3'd2);
    chk("clr_sr_value", out_value, 2);
    chk("clr_sr_valid", out_valid, 1);
    tick();

    // candidate completing with clear is discarded
    send_bit(1'b0);
    send_bit(1'b1);
    clear = 1'b1;
    send_bit(1'b1);
    clear = 1'b0;
    chk("clr_cand_valid", out_valid, 0);
    chk("clr_cand_drop", drop_cnt, 0);
    send_val(3'd5);
    chk("post_clr_value", out_value, 5);
    chk("post_clr_valid", out_valid, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/random_range_sampler.md
Name: random_range_sampler

Overview:
- Sits directly downstream of the LFSR random-bit source and consumes its serial random-bit stream.
- Packs WIDTH consecutive bits into a candidate number.
- Uses rejection sampling to discard candidates >= RANGE, so accepted values are uniform over 0..RANGE-1.
- Delivers accepted values through a 2-entry FIFO with a valid/ready handshake to consumers such as dice/game logic.

Parameters:
- WIDTH, 3, bits per candidate; legal range 1..16.
- RANGE, 6, exclusive upper bound of output values; legal range 1..2^WIDTH. If RANGE == 2^WIDTH, no candidate is ever rejected.
- CNT_W, 8, width of the saturating statistics counters.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush of collector and FIFO; counters are kept.
- in_bit  input  1  random bit from the upstream LFSR.
- in_valid  input  1  in_bit is valid this cycle; tie high for a free-running LFSR.
- out_value  output  WIDTH  FIFO head value.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_value this cycle.
- reject_cnt  output  CNT_W  saturating count of rejected candidates.
- drop_cnt  output  CNT_W  saturating count of in-range candidates dropped because the FIFO was full.
- level  output  2  FIFO occupancy, 0..2.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Collector shift register and bit counter go to 0; FIFO is emptied.
  - out_valid=0, out_value=0, level=0, reject_cnt=0, drop_cnt=0.
  - Reset mid-collection discards any partial bits.
- Collector:
  - On each clk edge with in_valid=1: sr <= {sr[WIDTH-2:0], in_bit}, so the first bit received becomes the MSB.
  - bit_cnt increments 0..WIDTH-1 and then wraps to 0.
  - in_valid=0 holds both sr and bit_cnt.
  - For WIDTH=1, every valid bit is a candidate.
- Candidate evaluation:
  - When in_valid=1 and bit_cnt==WIDTH-1, cand = {sr[WIDTH-2:0], in_bit}. It is evaluated combinationally and its disposition takes effect at that same edge.
  - If cand >= RANGE: candidate is discarded and reject_cnt increments.
  - Else, if a FIFO slot is available after this cycle's pop: cand is pushed.
  - Else: cand is dropped and drop_cnt increments.
- Counters:
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - They are cleared only by rst_n.
- FIFO (2 entries, registered storage):
  - out_value is driven from the head register; out_valid = (level != 0).
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle are legal at any level. When full, the pop frees a slot so the push succeeds with no drop, and level stays 2.
  - Push while empty with no pop: out_valid rises the cycle after the edge that captured the last bit. Latency is 1 cycle from the final bit edge to out_valid.
  - While out_valid=1 and out_ready=0, out_value and out_valid are held stable; this is AXI-style, and no value may change under a stalled handshake.
  - out_ready while empty is ignored.
  - FIFO order is strict: values are delivered in acceptance order.
- clear:
  - Same-edge flush: bit_cnt=0, sr=0, level=0, out_valid=0 at the next cycle.
  - A candidate completing in the same cycle as clear is discarded and not counted.
  - clear has priority over push and pop.
- out_value when empty: holds last head contents; consumers must qualify it with out_valid.

Test Plan:
- Basic push: WIDTH=3, RANGE=6, out_ready=1. Feed bits 0,1,0 on consecutive cycles -> out_valid=1 with out_value=2 exactly one cycle after the third bit edge, for one cycle only; level returns to 0.
- Rejection: feed bits 1,1,1 (7) then 1,1,0 (6) -> no out_valid, reject_cnt=2. Then feed 1,0,1 -> out_value=5, out_valid=1.
- Backpressure and drop: out_ready=0. Feed candidates 1, 2, 3 -> level=2, out_value stays 1 throughout, drop_cnt=1. Raise out_ready -> values 1 then 2 are delivered on successive cycles.
- Full with simultaneous push and pop: level=2 with values 1,2, out_ready=1 in the cycle the candidate 4 completes -> drop_cnt unchanged, level=2, subsequent outputs are 2 then 4.
- Gaps and reset: in_valid pattern 1,0,0,1,0,1 carrying bits 0,x,x,1,x,1 -> out_value=3. Separately, assert rst_n=0 after 2 of 3 bits; after release, feed 1,0,0 -> out_value=4, proving the partial bits were discarded.
- Saturation: CNT_W=2. Feed 5 rejected candidates (value 7) -> reject_cnt reads 3 and does not wrap. Then pulse clear with level=1 -> out_valid=0 the next cycle, reject_cnt still 3.
